// File: rtl/genius_pkg.sv
// Shared definitions for the Genius (Simon) memory game controller.
// Holds the controller state encoding, the colour codes and a small helper
// that classifies states as busy or resting.
package genius_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADD,
    ST_SHOW_ON,
    ST_SHOW_OFF,
    ST_WAIT_KEY,
    ST_LOSE,
    ST_WIN
  } state_t;

  typedef enum logic [1:0] {
    GREEN  = 2'd0,
    RED    = 2'd1,
    YELLOW = 2'd2,
    BLUE   = 2'd3
  } color_t;

  // Resting states are the ones where a new game may be started.
  function automatic logic state_busy(input state_t s);
    return !(s inside {ST_IDLE, ST_WIN, ST_LOSE});
  endfunction

endpackage

// File: rtl/genius_seq_mem.sv
// Colour sequence storage for the Genius game controller.
// Ports:
//   clk   - write clock (rising edge)
//   we    - write enable
//   waddr - write address
//   wdata - 2-bit colour to store
//   raddr - read address
//   rdata - combinational read of mem[raddr]
// Contents are not reset; only entries below the current length are read.
module genius_seq_mem #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [1:0]        wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [1:0]        rdata
);

  logic [1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/genius_game_ctrl.sv
// Genius (Simon) game controller.
// Each round appends a random colour to the sequence, plays the whole
// sequence back on the lamp, then waits for the player to repeat it.
// Ports:
//   clk_pll   - system clock, rising edge
//   reset     - synchronous active-high reset
//   start     - begin a new game (honoured only in IDLE/WIN/LOSE)
//   key_valid - key strobe; a press is its rising edge
//   key_color - colour of the pressed key
//   rnd       - free-running random colour, sampled when a colour is added
//   led_on    - lamp enable during playback
//   led_color - colour shown while led_on, otherwise 0
//   level     - current sequence length
//   busy      - high outside IDLE/WIN/LOSE
//   game_over - high in LOSE
//   win       - high in WIN
module genius_game_ctrl
  import genius_pkg::*;
#(
  parameter int unsigned MAX_LEN     = 16,
  parameter int unsigned ON_CYC      = 25_000_000,
  parameter int unsigned OFF_CYC     = 12_500_000,
  parameter int unsigned TIMEOUT_CYC = 250_000_000
) (
  input  logic                         clk_pll,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         key_valid,
  input  logic [1:0]                   key_color,
  input  logic [1:0]                   rnd,
  output logic                         led_on,
  output logic [1:0]                   led_color,
  output logic [$clog2(MAX_LEN+1)-1:0] level,
  output logic                         busy,
  output logic                         game_over,
  output logic                         win
);

  localparam int unsigned LEN_W    = $clog2(MAX_LEN + 1);
  localparam int unsigned ADDR_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int unsigned SHOW_MAX = (ON_CYC > OFF_CYC) ? ON_CYC : OFF_CYC;
  localparam int unsigned TMR_MAX  = (TIMEOUT_CYC > SHOW_MAX) ? TIMEOUT_CYC : SHOW_MAX;
  localparam int unsigned TMR_W    = $clog2(TMR_MAX + 1);

  state_t             state_q, state_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   idx_q, idx_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic               key_prev_q;

  logic               mem_we;
  logic [1:0]         seq_rd;
  logic               press;
  logic               last;

  genius_seq_mem #(
    .DEPTH  (MAX_LEN),
    .ADDR_W (ADDR_W)
  ) u_seq_mem (
    .clk   (clk_pll),
    .we    (mem_we),
    .waddr (ADDR_W'(len_q)),
    .wdata (rnd),
    .raddr (ADDR_W'(idx_q)),
    .rdata (seq_rd)
  );

  // key_prev_q tracks key_valid in every state, so a level already high on
  // entry to WAIT_KEY never looks like a fresh edge.
  assign press = key_valid & ~key_prev_q;
  assign last  = ((idx_q + 1'b1) == len_q);

  always_ff @(posedge clk_pll) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      idx_q      <= '0;
      tmr_q      <= '0;
      key_prev_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      tmr_q      <= tmr_d;
      key_prev_q <= key_valid;
    end
  end

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    idx_d     = idx_q;
    // Free-running, saturating cycle counter; each state clears it on exit.
    tmr_d     = (tmr_q == TMR_W'(TMR_MAX)) ? tmr_q : tmr_q + 1'b1;
    mem_we    = 1'b0;
    led_on    = 1'b0;
    led_color = GREEN;

    unique case (state_q)
      ST_IDLE, ST_WIN, ST_LOSE: begin
        if (start) begin
          len_d   = '0;
          idx_d   = '0;
          tmr_d   = '0;
          state_d = ST_ADD;
        end
      end

      ST_ADD: begin
        mem_we  = 1'b1;
        len_d   = len_q + 1'b1;
        idx_d   = '0;
        tmr_d   = '0;
        state_d = ST_SHOW_ON;
      end

      ST_SHOW_ON: begin
        led_on    = 1'b1;
        led_color = seq_rd;
        if (tmr_q >= TMR_W'(ON_CYC - 1)) begin
          tmr_d   = '0;
          state_d = ST_SHOW_OFF;
        end
      end

      ST_SHOW_OFF: begin
        if (tmr_q >= TMR_W'(OFF_CYC - 1)) begin
          tmr_d = '0;
          if (last) begin
            idx_d   = '0;
            state_d = ST_WAIT_KEY;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = ST_SHOW_ON;
          end
        end
      end

      ST_WAIT_KEY: begin
        // A press in the timeout cycle wins over the timeout.
        if (press) begin
          tmr_d = '0;
          if (key_color != seq_rd) begin
            state_d = ST_LOSE;
          end else if (!last) begin
            idx_d = idx_q + 1'b1;
          end else if (len_q == LEN_W'(MAX_LEN)) begin
            state_d = ST_WIN;
          end else begin
            state_d = ST_ADD;
          end
        end else if (tmr_q >= TMR_W'(TIMEOUT_CYC - 1)) begin
          state_d = ST_LOSE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign level     = len_q;
  assign busy      = state_busy(state_q);
  assign game_over = (state_q == ST_LOSE);
  assign win       = (state_q == ST_WIN);

endmodule

// File: tb/tb_genius_game_ctrl.sv
// Randomized scoreboard bench for genius_game_ctrl.
module tb_genius_game_ctrl;

  localparam int MAXL = 4;
  localparam int ONC  = 4;
  localparam int OFFC = 2;
  localparam int TOC  = 20;

  localparam int K_LAMP = 0;
  localparam int K_LOSE = 1;
  localparam int K_WIN  = 2;

  localparam int M_WIN     = 0;
  localparam int M_WRONG   = 1;
  localparam int M_TIMEOUT = 2;

  logic       clk_pll = 1'b0;
  logic       reset;
  logic       start;
  logic       key_valid;
  logic [1:0] key_color;
  logic [1:0] rnd;
  logic       led_on;
  logic [1:0] led_color;
  logic [2:0] level;
  logic       busy;
  logic       game_over;
  logic       win;

  genius_game_ctrl #(
    .MAX_LEN     (MAXL),
    .ON_CYC      (ONC),
    .OFF_CYC     (OFFC),
    .TIMEOUT_CYC (TOC)
  ) dut (
    .clk_pll   (clk_pll),
    .reset     (reset),
    .start     (start),
    .key_valid (key_valid),
    .key_color (key_color),
    .rnd       (rnd),
    .led_on    (led_on),
    .led_color (led_color),
    .level     (level),
    .busy      (busy),
    .game_over (game_over),
    .win       (win)
  );

  always #5 clk_pll = ~clk_pll;

  typedef struct {
    int kind;
    int col;
    int t;
    int dur;
    int lvl;
    int bsy;
    int go;
    int wn;
  } ev_t;

  ev_t exp_q[$];
  int  seq_m[$];
  int  cyc   = 0;
  int  total = 0;
  int  bad   = 0;
  bit  mon_en = 1'b0;

  always @(posedge clk_pll) cyc <= cyc + 1;

  function automatic ev_t mk(input int kind, input int col, input int t, input int dur,
                             input int lvl, input int bsy, input int go, input int wn);
    ev_t e;
    e.kind = kind; e.col = col; e.t = t; e.dur = dur;
    e.lvl = lvl; e.bsy = bsy; e.go = go; e.wn = wn;
    return e;
  endfunction

  function automatic void chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  function automatic void chk_ev(input ev_t a);
    ev_t e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL unexpected_event: got kind=%0d t=%0d lvl=%0d, want no event", a.kind, a.t, a.lvl);
      return;
    end
    e = exp_q.pop_front();
    if (a.kind != e.kind || a.col != e.col || a.t != e.t || a.dur != e.dur ||
        a.lvl != e.lvl || a.bsy != e.bsy || a.go != e.go || a.wn != e.wn) begin
      bad++;
      $display("FAIL event: got kind=%0d col=%0d t=%0d dur=%0d lvl=%0d busy=%0d go=%0d win=%0d, want kind=%0d col=%0d t=%0d dur=%0d lvl=%0d busy=%0d go=%0d win=%0d",
               a.kind, a.col, a.t, a.dur, a.lvl, a.bsy, a.go, a.wn,
               e.kind, e.col, e.t, e.dur, e.lvl, e.bsy, e.go, e.wn);
    end
  endfunction

  // Monitor: turns output activity into lamp / lose / win events.
  int   l_rise, l_col, l_lvl, l_bsy, l_go, l_wn;
  logic p_led = 1'b0;
  logic p_go  = 1'b0;
  logic p_win = 1'b0;

  always @(posedge clk_pll) begin
    #1;
    if (mon_en) begin
      if (led_on && !p_led) begin
        l_rise = cyc;
        l_col  = int'(led_color);
        l_lvl  = int'(level);
        l_bsy  = int'(busy);
        l_go   = int'(game_over);
        l_wn   = int'(win);
      end else if (led_on) begin
        chk("lamp_colour_steady", int'(led_color), l_col);
      end
      if (!led_on) chk("dark_colour_zero", int'(led_color), 0);
      if (!led_on && p_led)
        chk_ev(mk(K_LAMP, l_col, l_rise, cyc - l_rise, l_lvl, l_bsy, l_go, l_wn));
      if (game_over && !p_go)
        chk_ev(mk(K_LOSE, 0, cyc, 0, int'(level), int'(busy), 1, int'(win)));
      if (win && !p_win)
        chk_ev(mk(K_WIN, 0, cyc, 0, int'(level), int'(busy), int'(game_over), 1));
      p_led = led_on;
      p_go  = game_over;
      p_win = win;
    end
  end

  task automatic tick();
    @(negedge clk_pll);
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) begin
      tick();
      rnd = 2'($urandom_range(0, 3));
    end
  endtask

  // Playback of the whole sequence starts two cycles after the trigger.
  task automatic push_lamps(input int n);
    for (int k = 0; k < seq_m.size(); k++)
      exp_q.push_back(mk(K_LAMP, seq_m[k], n + 2 + k * (ONC + OFFC), ONC, seq_m.size(), 1, 0, 0));
  endtask

  task automatic push_end(input int kind, input int t);
    exp_q.push_back(mk(kind, 0, t, 0, seq_m.size(), 0, int'(kind == K_LOSE), int'(kind == K_WIN)));
  endtask

  // Random key/start/rnd noise during playback; quiet on the last cycle
  // before input, optionally leaving a stale key level high across it.
  task automatic playback_noise(input int n, input int w, input bit stale);
    while (cyc < w - 1) begin
      tick();
      if (cyc < w - 1) begin
        if (cyc >= n + 2) begin
          rnd       = 2'($urandom_range(0, 3));
          key_valid = ($urandom_range(0, 2) == 0);
          key_color = 2'($urandom_range(0, 3));
          start     = ($urandom_range(0, 5) == 0);
        end
      end else begin
        start     = 1'b0;
        key_valid = stale;
        key_color = ~2'(seq_m[0]);
      end
    end
  endtask

  task automatic run_game(input int mode, input int f_round, input int f_key, input bit f19);
    int n, w, ws, p, d, lo, h, len;
    bit stale, done;
    logic [1:0] c;
    rnd = 2'($urandom_range(0, 3));
    seq_m.delete();
    seq_m.push_back(int'(rnd));
    start = 1'b1;
    n = cyc;
    push_lamps(n);
    tick();
    start = 1'b0;
    done = 1'b0;
    while (!done) begin
      len   = seq_m.size();
      w     = n + 2 + len * (ONC + OFFC);
      stale = ($urandom_range(0, 3) == 0);
      playback_noise(n, w, stale);
      ws = w;
      lo = 0;
      if (stale) begin
        tick();
        tick();
        key_valid = 1'b0;
        lo = 2;
      end
      for (int i = 0; i < len && !done; i++) begin
        if (mode == M_TIMEOUT && len == f_round && i == f_key) begin
          push_end(K_LOSE, ws + TOC);
          wait_to(ws + TOC + 1);
          done = 1'b1;
        end else begin
          d = f19 ? 19 : int'($urandom_range(lo, 12));
          if (!f19 && $urandom_range(0, 7) == 0) d = 19;
          wait_to(ws + d);
          p = cyc;
          c = 2'(seq_m[i]);
          if (mode == M_WRONG && len == f_round && i == f_key) begin
            c = c ^ 2'($urandom_range(1, 3));
            push_end(K_LOSE, p + 1);
            done = 1'b1;
          end else if (i == len - 1) begin
            if (len == MAXL) begin
              push_end(K_WIN, p + 1);
              done = 1'b1;
            end else begin
              rnd = 2'($urandom_range(0, 3));
              seq_m.push_back(int'(rnd));
              n = p;
              push_lamps(n);
            end
          end
          key_color = c;
          key_valid = 1'b1;
          h = $urandom_range(1, 4);
          repeat (h) tick();
          key_valid = 1'b0;
          ws = p + 1;
          lo = h;
        end
      end
    end
  endtask

  task automatic run_reset_game();
    int n, r;
    rnd = 2'($urandom_range(0, 3));
    seq_m.delete();
    seq_m.push_back(int'(rnd));
    start = 1'b1;
    n = cyc;
    tick();
    start = 1'b0;
    r = $urandom_range(0, ONC - 2);
    exp_q.push_back(mk(K_LAMP, seq_m[0], n + 2, r + 1, 1, 1, 0, 0));
    wait_to(n + 2 + r);
    reset     = 1'b1;
    start     = 1'b1;
    key_valid = 1'b1;
    tick();
    reset     = 1'b0;
    start     = 1'b0;
    key_valid = 1'b0;
    chk("rst_mid_led_on", int'(led_on), 0);
    chk("rst_mid_led_color", int'(led_color), 0);
    chk("rst_mid_level", int'(level), 0);
    chk("rst_mid_busy", int'(busy), 0);
    chk("rst_mid_game_over", int'(game_over), 0);
    chk("rst_mid_win", int'(win), 0);
  endtask

  initial begin
    #2_000_000;
    bad++;
    $display("FAIL watchdog: got still running, want finished (cycle %0d)", cyc);
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int mode, fr, fk;
    reset     = 1'b1;
    start     = 1'b0;
    key_valid = 1'b0;
    key_color = 2'd0;
    rnd       = 2'd0;
    repeat (3) tick();
    reset = 1'b0;
    chk("rst_led_on", int'(led_on), 0);
    chk("rst_led_color", int'(led_color), 0);
    chk("rst_level", int'(level), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_game_over", int'(game_over), 0);
    chk("rst_win", int'(win), 0);
    mon_en = 1'b1;
    tick();

    run_game(M_WIN, 0, 0, 1'b1);
    repeat (2) tick();
    run_game(M_WRONG, 2, 1, 1'b0);
    repeat (2) tick();
    run_game(M_TIMEOUT, 1, 0, 1'b0);
    repeat (2) tick();
    run_game(M_TIMEOUT, 3, 2, 1'b0);
    repeat (2) tick();
    run_reset_game();
    repeat (2) tick();
    run_game(M_WIN, 0, 0, 1'b0);

    for (int g = 0; g < 25; g++) begin
      repeat ($urandom_range(1, 3)) tick();
      mode = $urandom_range(0, 2);
      fr   = $urandom_range(1, MAXL);
      fk   = $urandom_range(0, fr - 1);
      if (g % 6 == 5) run_reset_game();
      else run_game(mode, fr, fk, 1'b0);
    end

    repeat (20) tick();
    chk("leftover_expected", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/genius_game_ctrl.md
GENIUS_GAME_CTRL -- requirements
Module: genius_game_ctrl

Interface
REQ-001 SHALL have parameter MAX_LEN, default 16, maximum sequence length (rounds to win).
REQ-002 SHALL have parameter ON_CYC, default 25_000_000, clk_pll cycles each colour is lit during playback.
REQ-003 SHALL have parameter OFF_CYC, default 12_500_000, dark clk_pll cycles after each lit colour.
REQ-004 SHALL have parameter TIMEOUT_CYC, default 250_000_000, maximum clk_pll cycles allowed between player key presses.
REQ-005 SHALL have port clk_pll  input  1  single system clock; all logic on its rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port start  input  1  request to begin a new game, sampled each cycle.
REQ-008 SHALL have port key_valid  input  1  decoded-key strobe; may stay high several consecutive cycles per press.
REQ-009 SHALL have port key_color  input  2  colour of the pressed key, stable while key_valid is high.
REQ-010 SHALL have port rnd  input  2  free-running random colour source.
REQ-011 SHALL have port led_on  output  1  playback lamp enable.
REQ-012 SHALL have port led_color  output  2  colour being shown when led_on=1, otherwise 0.
REQ-013 SHALL have port level  output  $clog2(MAX_LEN+1)  current sequence length.
REQ-014 SHALL have port busy  output  1  high in every state except IDLE, WIN and LOSE.
REQ-015 SHALL have port game_over  output  1  high in LOSE.
REQ-016 SHALL have port win  output  1  high in WIN.

Function
REQ-017 SHALL implement states IDLE, ADD, SHOW_ON, SHOW_OFF, WAIT_KEY, LOSE and WIN.
REQ-018 SHALL, on start=1 in IDLE, WIN or LOSE, clear len, idx and the timer, and enter ADD on the next cycle; start SHALL be ignored in all other states.
REQ-019 SHALL, in ADD (one cycle), write seq[len] <= rnd, increment len, clear idx and the timer, and enter SHOW_ON.
REQ-020 SHALL, in SHOW_ON, drive led_on=1 and led_color=seq[idx] for exactly ON_CYC cycles, then enter SHOW_OFF with the timer cleared.
REQ-021 SHALL, in SHOW_OFF, drive led_on=0 for exactly OFF_CYC cycles, then:
  - if idx+1 == len: enter WAIT_KEY with idx=0 and the timer cleared;
  - otherwise: increment idx and enter SHOW_ON.
REQ-022 SHALL treat a key press as the rising edge of key_valid, using a registered previous value; a held-high key_valid SHALL count as one press.
REQ-023 SHALL ignore key presses in every state except WAIT_KEY, and SHALL register the previous key_valid value in all states so that a level already high when WAIT_KEY is entered is not counted as a press.
REQ-024 SHALL, on a key press in WAIT_KEY, compare key_color with seq[idx] in the cycle the edge is detected, clear the timer, and then:
  - on mismatch: enter LOSE;
  - on a match with idx+1 < len: increment idx and stay in WAIT_KEY;
  - on a match with idx+1 == len and len == MAX_LEN: enter WIN;
  - on a match with idx+1 == len and len < MAX_LEN: enter ADD.
REQ-025 SHALL enter LOSE when the timer reaches TIMEOUT_CYC in WAIT_KEY without a key press; a press arriving in that same cycle SHALL take priority over the timeout.
REQ-026 SHALL hold level=len at all times; len SHALL never exceed MAX_LEN, and the timer SHALL saturate rather than wrap.
REQ-027 SHALL keep level at its final value in LOSE and WIN until the next game starts.

Reset
REQ-028 SHALL, on reset=1 at a rising clk_pll edge, enter IDLE and clear len, idx, the timer and the previous-key_valid register; led_on, led_color, level, busy, game_over and win SHALL all read 0 in the following cycle.
REQ-029 SHALL let reset take priority over start and key presses, and SHALL abort playback or input wait at once; sequence memory contents need not be cleared.

Structure
REQ-030 SHALL take the state encoding and the colour codes (GREEN=0, RED=1, YELLOW=2, BLUE=3) from shared package genius_pkg.
REQ-031 SHALL place sequence storage (MAX_LEN x 2-bit, one write port, one combinational read port) in sub-module genius_seq_mem.

Verification (MAX_LEN=4, ON_CYC=4, OFF_CYC=2, TIMEOUT_CYC=20)
REQ-032 SHALL test start with rnd=2 -> ADD, then led_on=1 with led_color=2 for 4 cycles, led_on=0 for 2 cycles, then WAIT_KEY with level=1.
REQ-033 SHALL test key_color=2 with key_valid held 4 cycles in round 1 -> one press counted, ADD, level=2, playback of 2 colours (12 cycles total).
REQ-034 SHALL test a wrong colour on the second key of round 2 -> game_over=1, busy=0, level=2; then start -> level=1, game_over=0.
REQ-035 SHALL test no key for 20 cycles in WAIT_KEY -> LOSE; also a key edge in the 20th cycle -> the compare is used and no LOSE occurs.
REQ-036 SHALL test 4 correct rounds -> win=1 with level=4; key pulses during SHOW_ON/SHOW_OFF cause no state change.
REQ-037 SHALL test reset asserted mid-SHOW_ON -> next cycle IDLE with all outputs 0.
